neuron_tdm_core: RTL and testbench

Time-multiplexed LIF neuron core holding membrane and refractory state for NUM_NEURONS neurons in internal register arrays. It replaces per-neuron external state write-back with an event-driven integrate port, a tick-triggered leak/fire sweep, and a back-pressured spike output stream with a small spike FIFO. It sits between the synapse/event router and the spike encoder/AER output.

---
 rtl/neuron_tdm_core.sv | 221 ++++++++++++++++++++++
 tb/tb_neuron_tdm_core.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_tdm_core.sv
// Time-multiplexed LIF neuron core: event integrate, tick-driven leak/fire sweep, spike FIFO.
// Latency: event integrated next edge; sweep NUM_NEURONS cycles + stalls, then one DONE cycle.
// Backpressure: events accepted only in IDLE; sweep stalls while the spike FIFO is full.
module neuron_tdm_core #(
    parameter int NUM_NEURONS       = 16,
    parameter int VMEM_WIDTH        = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int V_THRESH          = 120,
    parameter int V_RESET           = 0,
    parameter int LEAK_MODE         = 0,
    parameter int LEAK_VAL          = 2,
    parameter int LEAK_SHIFT        = 3,
    parameter int REFRACTORY_PERIOD = 5,
    parameter int SPK_FIFO_DEPTH    = 4,
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_tick,
    input  logic                         i_ev_valid,
    output logic                         o_ev_ready,
    input  logic [IDX_W-1:0]             i_ev_idx,
    input  logic signed [DATA_WIDTH-1:0] i_ev_current,
    output logic                         o_spk_valid,
    input  logic                         i_spk_ready,
    output logic [IDX_W-1:0]             o_spk_idx,
    output logic                         o_busy,
    output logic                         o_sweep_done,
    output logic                         o_idx_err
);

    localparam int W     = VMEM_WIDTH;
    localparam int REF_W = (REFRACTORY_PERIOD > 0) ? $clog2(REFRACTORY_PERIOD + 1) : 1;
    localparam int FA_W  = $clog2(SPK_FIFO_DEPTH);

    // Arithmetic is done one bit wider than vmem so clamps can see overflow/underflow.
    localparam logic signed [W:0]   VMAX_X   = (W+1)'((1 << (W - 1)) - 1);
    localparam logic signed [W-1:0] VMAX_V   = W'((1 << (W - 1)) - 1);
    localparam logic signed [W:0]   VRST_X   = (W+1)'(V_RESET);
    localparam logic signed [W-1:0] VRST_V   = W'(V_RESET);
    localparam logic signed [W:0]   VTH_X    = (W+1)'(V_THRESH);
    localparam logic signed [W:0]   LEAK_X   = (W+1)'(LEAK_VAL);
    localparam logic [REF_W-1:0]    REF_INIT = REF_W'(REFRACTORY_PERIOD);
    localparam logic [REF_W-1:0]    REF_ONE  = REF_W'(1);
    localparam logic [IDX_W:0]      NUM_X    = (IDX_W+1)'(NUM_NEURONS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [FA_W:0]       DEPTH_X  = (FA_W+1)'(SPK_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  pend_q, pend_d;
    logic                  err_q;

    logic signed [W-1:0]   vmem_q [NUM_NEURONS];
    logic [REF_W-1:0]      ref_q  [NUM_NEURONS];

    logic [IDX_W-1:0]      fifo_q [SPK_FIFO_DEPTH];
    logic [FA_W-1:0]       wr_q, rd_q;
    logic [FA_W:0]         cnt_q;

    // Event path signals
    logic                  ev_acc, ev_in_rng, ev_write;
    logic signed [W:0]     ev_sum;
    logic signed [W-1:0]   ev_new;

    // Sweep path signals
    logic signed [W:0]     cur_vx, leak_amt, leaked;
    logic [REF_W-1:0]      cur_ref;
    logic                  fire, fifo_full, proc, push, pop, start;

    // Event integration: saturating add of the sign-extended current.
    always_comb begin
        ev_acc    = i_ev_valid && (state_q == S_IDLE);
        ev_in_rng = ({1'b0, i_ev_idx} < NUM_X);
        ev_sum    = (W+1)'(vmem_q[i_ev_idx]) + (W+1)'(i_ev_current);
        ev_new    = ev_sum[W-1:0];
        if (ev_sum > VMAX_X) begin
            ev_new = VMAX_V;
        end else if (ev_sum < VRST_X) begin
            ev_new = VRST_V;
        end
        ev_write  = ev_acc && ev_in_rng && (ref_q[i_ev_idx] == '0);
    end

    // Sweep datapath: leak the neuron under the pointer and decide whether it fires.
    always_comb begin
        cur_vx  = (W+1)'(vmem_q[ptr_q]);
        cur_ref = ref_q[ptr_q];
        if (LEAK_MODE == 0) begin
            leak_amt = LEAK_X;
        end else begin
            leak_amt = (cur_vx - VRST_X) >>> LEAK_SHIFT;
        end
        leaked = cur_vx - leak_amt;
        if (leaked < VRST_X) begin
            leaked = VRST_X;
        end
        fire      = (cur_ref == '0) && (leaked >= VTH_X);
        // Full-stall uses the pre-pop count so a same-cycle pop never races a push.
        fifo_full = (cnt_q == DEPTH_X);
        proc      = (state_q == S_SWEEP) && !fifo_full;
        push      = proc && fire;
        pop       = (cnt_q != '0) && i_spk_ready;
    end

    // Next-state logic: IDLE/SWEEP/DONE with a single collapsed pending-tick flag.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_tick || pend_q) begin
                    start   = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (proc) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // A queued tick starts the next sweep straight away, with no IDLE gap.
                if (i_tick || pend_q) begin
                    start   = 1'b1;
                    state_d = S_SWEEP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            pend_d = 1'b0;
            ptr_d  = '0;
        end else if ((state_q != S_IDLE) && i_tick) begin
            pend_d = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            err_q   <= ev_acc && !ev_in_rng;
        end
    end

    // Neuron state arrays: events write in IDLE, the sweep writes in SWEEP (never both).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                vmem_q[i] <= VRST_V;
                ref_q[i]  <= '0;
            end
        end else begin
            if (ev_write) begin
                vmem_q[i_ev_idx] <= ev_new;
            end
            if (proc) begin
                if (cur_ref != '0) begin
                    vmem_q[ptr_q] <= VRST_V;
                    ref_q[ptr_q]  <= cur_ref - REF_ONE;
                end else if (fire) begin
                    vmem_q[ptr_q] <= VRST_V;
                    ref_q[ptr_q]  <= REF_INIT;
                end else begin
                    vmem_q[ptr_q] <= leaked[W-1:0];
                end
            end
        end
    end

    // Spike FIFO, first-word-fall-through; storage is cleared so the idx output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SPK_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= ptr_q;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign o_ev_ready   = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_sweep_done = (state_q == S_DONE);
    assign o_spk_valid  = (cnt_q != '0);
    assign o_spk_idx    = fifo_q[rd_q];
    assign o_idx_err    = err_q;

endmodule

// File: tb/tb_neuron_tdm_core.sv
// Self-checking bench for neuron_tdm_core: scoreboard of expected spike indices,
// one task per scenario, spikes checked in order as the DUT hands them off.
module tb_neuron_tdm_core;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic              ev_valid = 1'b0;
    logic [3:0]        ev_idx = '0;
    logic signed [7:0] ev_cur = '0;
    logic              spk_ready = 1'b1;
    logic              ev_ready, spk_valid, busy, sweep_done, idx_err;
    logic [3:0]        spk_idx;

    // Second instance built with the exponential leak.
    logic              tick1 = 1'b0;
    logic              ev_valid1 = 1'b0;
    logic [3:0]        ev_idx1 = '0;
    logic signed [7:0] ev_cur1 = '0;
    logic              ev_ready1, spk_valid1, busy1, sweep_done1, idx_err1;
    logic [3:0]        spk_idx1;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb [$];

    always #5 clk = ~clk;

    neuron_tdm_core dut (
        .clk(clk), .rst_n(rst_n), .i_tick(tick),
        .i_ev_valid(ev_valid), .o_ev_ready(ev_ready), .i_ev_idx(ev_idx), .i_ev_current(ev_cur),
        .o_spk_valid(spk_valid), .i_spk_ready(spk_ready), .o_spk_idx(spk_idx),
        .o_busy(busy), .o_sweep_done(sweep_done), .o_idx_err(idx_err)
    );

    neuron_tdm_core #(.LEAK_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_tick(tick1),
        .i_ev_valid(ev_valid1), .o_ev_ready(ev_ready1), .i_ev_idx(ev_idx1), .i_ev_current(ev_cur1),
        .o_spk_valid(spk_valid1), .i_spk_ready(1'b1), .o_spk_idx(spk_idx1),
        .o_busy(busy1), .o_sweep_done(sweep_done1), .o_idx_err(idx_err1)
    );

    // Spike monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (rst_n && spk_valid && spk_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL spike_unexpected: got idx %0d, none expected", spk_idx);
            end else begin
                e = sb.pop_front();
                if (spk_idx !== e) begin
                    n_err++;
                    $display("FAIL spike_order: got idx %0d, expected %0d", spk_idx, e);
                end
            end
        end
        if (rst_n && spk_valid1) begin
            n_cmp++;
            n_err++;
            $display("FAIL leak1_spike: got idx %0d, expected no spike", spk_idx1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_ev(input logic [3:0] idx, input logic signed [7:0] cur);
        int n = 0;
        ev_valid = 1'b1;
        ev_idx   = idx;
        ev_cur   = cur;
        while (!ev_ready && n < 200) begin
            step();
            n++;
        end
        if (!ev_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ev_ready_timeout: ready=%0b after %0d cycles, expected 1", ev_ready, n);
        end
        step();
        ev_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!sweep_done && n < 300) begin
            step();
            n++;
        end
        n_cmp++;
        if (!sweep_done) begin
            n_err++;
            $display("FAIL sweep_done_timeout: done=%0b after %0d cycles, expected 1", sweep_done, n);
        end
        step();
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({spk_valid, busy, sweep_done, idx_err, spk_idx} !== 8'h00 || ev_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b done=%0b err=%0b idx=%0d rdy=%0b, expected 0 0 0 0 0 1",
                     spk_valid, busy, sweep_done, idx_err, spk_idx, ev_ready);
        end
        for (int i = 0; i < 16; i++) if (dut.vmem_q[i] !== 16'sd0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_vmem: %0d neurons nonzero, expected 0", bad);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_integrate_fire();
        int k = 0;
        send_ev(4'd3, 8'sd100);
        n_cmp++;
        if (dut.vmem_q[3] !== 16'sd100) begin
            n_err++;
            $display("FAIL integrate_100: vmem=%0d, expected 100", dut.vmem_q[3]);
        end
        do_tick();
        wait_done();
        n_cmp++;
        if (dut.vmem_q[3] !== 16'sd98 || spk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL leak_no_fire: vmem=%0d valid=%0b, expected 98 0", dut.vmem_q[3], spk_valid);
        end
        send_ev(4'd3, 8'sd30);
        sb.push_back(4'd3);
        tick = 1'b1;
        while (k < 40) begin
            step();
            tick = 1'b0;
            k++;
            if (sweep_done) break;
        end
        n_cmp++;
        if (k != 17) begin
            n_err++;
            $display("FAIL done_latency: %0d cycles, expected 17", k);
        end
        step();
        n_cmp++;
        if (dut.vmem_q[3] !== 16'sd0 || dut.ref_q[3] !== 3'd5) begin
            n_err++;
            $display("FAIL fire_reset: vmem=%0d ref=%0d, expected 0 5", dut.vmem_q[3], dut.ref_q[3]);
        end
    endtask

    task automatic test_refractory();
        for (int i = 0; i < 5; i++) begin
            send_ev(4'd3, 8'sd127);
            n_cmp++;
            if (dut.vmem_q[3] !== 16'sd0) begin
                n_err++;
                $display("FAIL refractory_drop%0d: vmem=%0d, expected 0", i, dut.vmem_q[3]);
            end
            do_tick();
            wait_done();
        end
        send_ev(4'd3, 8'sd127);
        n_cmp++;
        if (dut.vmem_q[3] !== 16'sd127) begin
            n_err++;
            $display("FAIL refractory_over: vmem=%0d, expected 127", dut.vmem_q[3]);
        end
        sb.push_back(4'd3);
        do_tick();
        wait_done();
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL refractory_spike: %0d spikes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_clamp();
        send_ev(4'd5, 8'sh80);
        n_cmp++;
        if (dut.vmem_q[5] !== 16'sd0) begin
            n_err++;
            $display("FAIL clamp_low: vmem=%0d, expected 0", dut.vmem_q[5]);
        end
        for (int i = 0; i < 300; i++) send_ev(4'd0, 8'sd127);
        n_cmp++;
        if (dut.vmem_q[0] !== 16'sd32767) begin
            n_err++;
            $display("FAIL clamp_high: vmem=%0d, expected 32767", dut.vmem_q[0]);
        end
        sb.push_back(4'd0);
        do_tick();
        wait_done();
        step();
        n_cmp++;
        if (dut.vmem_q[0] !== 16'sd0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL sat_fire: vmem=%0d pending=%0d, expected 0 0", dut.vmem_q[0], sb.size());
        end
        // Exponential leak instance: 80 - (80 >>> 3) = 70.
        ev_valid1 = 1'b1; ev_idx1 = 4'd0; ev_cur1 = 8'sd80;
        step();
        ev_valid1 = 1'b0;
        tick1 = 1'b1;
        step();
        tick1 = 1'b0;
        for (int n = 0; n < 40 && !sweep_done1; n++) step();
        step();
        n_cmp++;
        if (u_dut1.vmem_q[0] !== 16'sd70) begin
            n_err++;
            $display("FAIL leak_exp: vmem=%0d, expected 70", u_dut1.vmem_q[0]);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        apply_reset();
        spk_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_ev(4'(i), 8'sd127);
        for (int i = 0; i < 16; i++) sb.push_back(4'(i));
        do_tick();
        repeat (12) step();
        n_cmp++;
        if (busy !== 1'b1 || ev_ready !== 1'b0 || spk_valid !== 1'b1 || spk_idx !== 4'd0) begin
            n_err++;
            $display("FAIL stall_outputs: busy=%0b rdy=%0b valid=%0b idx=%0d, expected 1 0 1 0",
                     busy, ev_ready, spk_valid, spk_idx);
        end
        n_cmp++;
        if (dut.ptr_q !== 4'd4 || dut.cnt_q !== 3'd4) begin
            n_err++;
            $display("FAIL stall_ptr: ptr=%0d cnt=%0d, expected 4 4", dut.ptr_q, dut.cnt_q);
        end
        spk_ready = 1'b1;
        wait_done();
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d spikes missing, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int bad_rdy = 0;
        int extra = 0;
        do_tick();
        for (int k = 0; k < 120 && dones < 2; k++) begin
            tick = (k == 3 || k == 6);
            if (ev_ready) bad_rdy++;
            if (sweep_done) dones++;
            step();
        end
        tick = 1'b0;
        n_cmp++;
        if (dones != 2 || bad_rdy != 0) begin
            n_err++;
            $display("FAIL b2b_sweeps: dones=%0d ready_cycles=%0d, expected 2 0", dones, bad_rdy);
        end
        n_cmp++;
        if (busy !== 1'b0 || ev_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%0b rdy=%0b, expected 0 1", busy, ev_ready);
        end
        for (int k = 0; k < 30; k++) begin
            if (busy || sweep_done) extra++;
            step();
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL b2b_extra: %0d busy cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        int bad = 0;
        apply_reset();
        spk_ready = 1'b0;
        send_ev(4'd1, 8'sd127);
        send_ev(4'd2, 8'sd127);
        do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        while (dut.ptr_q !== 4'd7 && n < 50) begin
            step();
            n++;
        end
        n_cmp++;
        if (dut.cnt_q !== 3'd2 || dut.pend_q !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: cnt=%0d pend=%0b, expected 2 1", dut.cnt_q, dut.pend_q);
        end
        rst_n = 1'b0;
        step();
        sb.delete();
        n_cmp++;
        if ({spk_valid, busy, sweep_done, idx_err, spk_idx} !== 8'h00 || ev_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_outputs: valid=%0b busy=%0b done=%0b err=%0b idx=%0d rdy=%0b, expected 0 0 0 0 0 1",
                     spk_valid, busy, sweep_done, idx_err, spk_idx, ev_ready);
        end
        for (int i = 0; i < 16; i++) if (dut.vmem_q[i] !== 16'sd0) bad++;
        n_cmp++;
        if (bad != 0 || dut.pend_q !== 1'b0 || dut.state_q !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_state: nonzero_vmem=%0d pend=%0b state=%0d, expected 0 0 0",
                     bad, dut.pend_q, dut.state_q);
        end
        rst_n = 1'b1;
        spk_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy || spk_valid) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: %0d active cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_refractory();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sweep();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
